// File: rtl/conv_frame_sink_if.sv
// Output word stream of conv_frame_sink: one P-lane pixel word per beat with row/frame markers.
interface conv_frame_sink_if #(
  parameter int P = 4
) ();
  logic           m_valid;
  logic           m_ready;
  logic [P*8-1:0] m_data;
  logic           m_last_row;
  logic           m_last_frame;

  modport master (output m_valid, m_data, m_last_row, m_last_frame, input m_ready);
  modport slave  (input m_valid, m_data, m_last_row, m_last_frame, output m_ready);
endinterface

// File: rtl/conv_frame_sink.sv
// Captures one frame of P-lane convolver output, zero-fills invalid lanes, tracks raster
// position and buffers words in a FIFO toward a valid/ready sink with row/frame markers.
module conv_frame_sink #(
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int P          = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     beat,
  input  logic [P-1:0]             out_valid_vec,
  input  logic [P*8-1:0]           out_pix_vec,
  conv_frame_sink_if.master        m,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - P);
  localparam logic [CW-1:0] COL_STEP = CW'(P);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic           last_frame;
    logic           last_row;
    logic [P*8-1:0] data;
  } entry_t;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  entry_t        push_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic at_row_end, at_frame_end, take, push, pop, full;

  assign at_row_end   = (col == COL_LAST);
  assign at_frame_end = at_row_end && (row == ROW_LAST);
  assign take         = (state == ST_RUN) && beat;
  assign full         = (count == CNT_FULL);
  assign pop          = m.m_valid && m.m_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push         = take && (!full || pop);

  assign head           = mem[rd_ptr];
  assign m.m_valid      = (count != '0);
  assign m.m_data       = m.m_valid ? head.data : '0;
  assign m.m_last_row   = m.m_valid && head.last_row;
  assign m.m_last_frame = m.m_valid && head.last_frame;

  assign busy = (state != ST_IDLE);
  // Empty-in-DRAIN exit covers a frame whose final beat was dropped on overflow.
  assign frame_done = (state == ST_DRAIN) && ((pop && head.last_frame) || !m.m_valid);

  always_comb begin
    push_entry            = '0;
    push_entry.last_row   = at_row_end;
    push_entry.last_frame = at_frame_end;
    for (int l = 0; l < P; l++) begin
      push_entry.data[l*8 +: 8] = out_valid_vec[l] ? out_pix_vec[l*8 +: 8] : 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            col      <= '0;
            row      <= '0;
            overflow <= 1'b0;
          end
        end
        ST_RUN: begin
          if (beat) begin
            if (!push) overflow <= 1'b1;
            // Counters advance even on a dropped beat so geometry stays aligned.
            if (at_row_end) begin
              col <= '0;
              row <= at_frame_end ? '0 : row + RW'(1);
            end else begin
              col <= col + COL_STEP;
            end
            if (at_frame_end) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (frame_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count do, so contents are never observed stale.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sink.sv
// Self-checking bench for conv_frame_sink: queue-based reference of the frame capture
// compared every cycle, plus hand-computed literal expectations per directed scenario.
module tb_conv_frame_sink;

  localparam int WIDTH = 8;
  localparam int HEIGHT = 3;
  localparam int P = 4;
  localparam int DEPTH = 4;
  localparam int BPR = WIDTH / P;
  localparam int BEATS = BPR * HEIGHT;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           beat = 1'b0;
  logic [P-1:0]   vld = '0;
  logic [P*8-1:0] pix = '0;
  logic           busy, frame_done, overflow;

  conv_frame_sink_if #(.P(P)) s ();

  conv_frame_sink #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .P(P), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .beat(beat),
    .out_valid_vec(vld),
    .out_pix_vec(pix),
    .m(s),
    .busy(busy),
    .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] d;
    logic        lr;
    logic        lf;
  } wd_t;

  wd_t exp_q[$];
  wd_t got_q[$];
  wd_t w;
  wd_t g;
  bit  md_run = 0, md_drain = 0, md_ovf = 0;
  bit  was_run, was_drain, do_pop;
  int  k = 0;
  int  sz = 0;
  int  fd_cnt = 0;

  function automatic logic [31:0] lane_fill(input logic [3:0] v, input logic [31:0] p);
    return p & {{8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}}};
  endfunction

  function automatic logic [31:0] kw(input int n);
    return 32'h03020100 + 32'(n) * 32'h04040404;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      md_run = 0;
      md_drain = 0;
      md_ovf = 0;
      k = 0;
    end else begin
      was_run = md_run;
      was_drain = md_drain;
      sz = exp_q.size();
      do_pop = (sz != 0) && s.m_ready;
      if (do_pop) begin
        if (was_drain && exp_q[0].lf) md_drain = 0;
        void'(exp_q.pop_front());
      end
      if (!was_run && !was_drain && start) begin
        md_run = 1;
        k = 0;
        md_ovf = 0;
      end
      if (was_run && beat) begin
        w.d = lane_fill(vld, pix);
        w.lr = ((k % BPR) == BPR - 1);
        w.lf = (k == BEATS - 1);
        if (sz < DEPTH || do_pop) exp_q.push_back(w);
        else md_ovf = 1;
        k++;
        if (w.lf) begin
          md_run = 0;
          md_drain = 1;
        end
      end
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("m_valid", s.m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("m_data", s.m_data, exp_q[0].d);
      check("m_last_row", s.m_last_row, exp_q[0].lr);
      check("m_last_frame", s.m_last_frame, exp_q[0].lf);
    end
    check("busy", busy, md_run || md_drain);
    check("overflow", overflow, md_ovf);
    check("frame_done", frame_done,
          md_drain && exp_q.size() != 0 && exp_q[0].lf && s.m_ready);
  end

  // Transfer log used by the literal checks.
  always @(posedge clk) begin
    if (rst_n && s.m_valid && s.m_ready) begin
      g.d = s.m_data;
      g.lr = s.m_last_row;
      g.lf = s.m_last_frame;
      got_q.push_back(g);
    end
    if (rst_n && frame_done) fd_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v, input logic [31:0] p);
    beat = 1'b1;
    vld = v;
    pix = p;
    tick();
    beat = 1'b0;
    vld = '0;
    pix = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, busy, 1'b0);
  endtask

  task automatic clear_log();
    got_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_log(input string tag, input int n, input logic [5:0] lrm, input logic [5:0] lfm);
    logic [5:0] a_lr = '0;
    logic [5:0] a_lf = '0;
    check({tag, "_words"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      a_lr[i] = got_q[i].lr;
      a_lf[i] = got_q[i].lf;
    end
    check({tag, "_last_row_mask"}, a_lr, lrm);
    check({tag, "_last_frame_mask"}, a_lf, lfm);
    check({tag, "_frame_done_pulses"}, fd_cnt, 1);
  endtask

  function automatic logic [31:0] got_data(input int i);
    return (i < got_q.size()) ? got_q[i].d : 32'hDEADBEEF;
  endfunction

  initial begin
    s.m_ready = 1'b0;
    tick();
    tick();
    check("reset_m_valid", s.m_valid, 1'b0);
    check("reset_m_data", s.m_data, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    tick();

    // T1: full frame, sink always ready
    clear_log();
    s.m_ready = 1'b1;
    pulse_start();
    send(4'hF, kw(0));
    check("t1_latency_valid", s.m_valid, 1'b1);
    check("t1_latency_data", s.m_data, 32'h03020100);
    for (int i = 1; i < BEATS; i++) send(4'hF, kw(i));
    wait_idle("t1");
    check_log("t1", 6, 6'b101010, 6'b100000);
    check("t1_word3", got_data(3), 32'h0F0E0D0C);
    check("t1_word5", got_data(5), 32'h17161514);

    // T2: lane zero-fill
    clear_log();
    s.m_ready = 1'b0;
    pulse_start();
    send(4'b0101, 32'hAABBCCDD);
    check("t2_fill_a", s.m_data, 32'h00BB00DD);
    s.m_ready = 1'b1;
    send(4'b1010, 32'h11223344);
    check("t2_fill_b", s.m_data, 32'h11003300);
    for (int i = 2; i < BEATS; i++) send(4'hF, kw(i));
    wait_idle("t2");
    check_log("t2", 6, 6'b101010, 6'b100000);
    check("t2_word0", got_data(0), 32'h00BB00DD);

    // T3: overflow with stalled sink
    clear_log();
    s.m_ready = 1'b0;
    pulse_start();
    for (int i = 0; i <= DEPTH; i++) send(4'hF, kw(i));
    check("t3_overflow_set", overflow, 1'b1);
    check("t3_head", s.m_data, 32'h03020100);
    s.m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    send(4'hF, kw(5));
    wait_idle("t3");
    check_log("t3", 5, 6'b011010, 6'b010000);
    check("t3_word3", got_data(3), 32'h0F0E0D0C);
    check("t3_word4", got_data(4), 32'h17161514);
    check("t3_overflow_sticky", overflow, 1'b1);

    // T4: push into full FIFO with simultaneous pop
    clear_log();
    s.m_ready = 1'b0;
    pulse_start();
    check("t4_overflow_cleared", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(4'hF, kw(i));
    s.m_ready = 1'b1;
    send(4'hF, kw(4));
    check("t4_no_overflow", overflow, 1'b0);
    send(4'hF, kw(5));
    wait_idle("t4");
    check_log("t4", 6, 6'b101010, 6'b100000);
    check("t4_word4", got_data(4), 32'h13121110);

    // T5: beats before start ignored, second start ignored
    clear_log();
    s.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(4'hF, kw(9));
    check("t5_idle_valid", s.m_valid, 1'b0);
    check("t5_idle_busy", busy, 1'b0);
    pulse_start();
    send(4'hF, kw(0));
    send(4'hF, kw(1));
    start = 1'b1;
    send(4'hF, kw(2));
    start = 1'b0;
    for (int i = 3; i < BEATS; i++) send(4'hF, kw(i));
    wait_idle("t5");
    check_log("t5", 6, 6'b101010, 6'b100000);
    check("t5_word2", got_data(2), 32'h0B0A0908);
    send(4'hF, kw(7));
    check("t5_post_frame_valid", s.m_valid, 1'b0);

    // T6: reset mid-frame, then a fresh frame
    clear_log();
    s.m_ready = 1'b0;
    pulse_start();
    for (int i = 0; i <= DEPTH; i++) send(4'hF, kw(i));
    check("t6_pre_overflow", overflow, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", s.m_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_overflow", overflow, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    s.m_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < BEATS; i++) send(4'hF, kw(i + 20));
    wait_idle("t6");
    check_log("t6", 6, 6'b101010, 6'b100000);
    check("t6_word0", got_data(0), 32'h53525150);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
